// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types: response codes, write/read FSM states and address-LSB helper.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_e;

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_wr_collector.sv
// Pairs AXI-Lite AW and W beats in either order and owns the B channel.
// Emits a combinational commit strobe on the edge that completes the pair.
module axil_wr_collector
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter bit RO_REG0    = 1'b0,
    localparam int IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic                  cmt_o,
    output logic [IDX_W-1:0]      cmt_idx_o,
    output logic [DATA_WIDTH-1:0] cmt_data_o,
    output logic                  cmt_err_o
);
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);

    wr_state_e             state_q;
    logic                  awready_q, wready_q, bvalid_q;
    axi_resp_e             bresp_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  aw_hs, w_hs, have_aw, have_w;
    logic [ADDR_WIDTH-1:0] cur_addr;

    assign aw_hs   = AWVALID && awready_q;
    assign w_hs    = WVALID && wready_q;
    assign have_aw = aw_hs || (state_q == W_HAVE_AW);
    assign have_w  = w_hs || (state_q == W_HAVE_W);

    // Whichever half arrived earlier comes from its latch, the other straight off the bus.
    assign cur_addr   = (state_q == W_HAVE_AW) ? addr_q : AWADDR;
    assign cmt_o      = have_aw && have_w;
    assign cmt_idx_o  = cur_addr[ADDR_LSB +: IDX_W];
    assign cmt_data_o = (state_q == W_HAVE_W) ? data_q : WDATA;
    assign cmt_err_o  = ((cur_addr >> (ADDR_LSB + IDX_W)) != '0) ||
                        (RO_REG0 && (cmt_idx_o == '0));

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            if (aw_hs) addr_q <= AWADDR;
            if (w_hs)  data_q <= WDATA;
            case (state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (cmt_o) begin
                        state_q   <= W_RESP;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else if (aw_hs) begin
                        state_q   <= W_HAVE_AW;
                        awready_q <= 1'b0;
                    end else if (w_hs) begin
                        state_q  <= W_HAVE_W;
                        wready_q <= 1'b0;
                    end
                end
                W_HAVE_AW: if (cmt_o) begin
                    state_q  <= W_RESP;
                    wready_q <= 1'b0;
                end
                W_HAVE_W: if (cmt_o) begin
                    state_q   <= W_RESP;
                    awready_q <= 1'b0;
                end
                W_RESP: if (BREADY) begin
                    state_q   <= W_IDLE;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    bvalid_q  <= 1'b0;
                end
                default: state_q <= W_IDLE;
            endcase
            if (cmt_o) begin
                bvalid_q <= 1'b1;
                bresp_q  <= cmt_err_o ? SLVERR : OKAY;
            end
        end
    end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI-Lite register file slave: NUM_REGS words, flat reg_out export.
// Define AXIL_REGFILE_ID_REG_EN to make register 0 a read-only ID_VALUE.
module axil_regfile_slave
    import axi_lite_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_REGS   = 8,
    parameter logic [31:0] ID_VALUE   = 32'hA11C_0001
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
`ifdef AXIL_REGFILE_ID_REG_EN
    localparam bit RO_REG0 = 1'b1;
`else
    localparam bit RO_REG0 = 1'b0;
`endif
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [DATA_WIDTH-1:0] ID_WORD = DATA_WIDTH'(ID_VALUE);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic                  cmt;
    logic [IDX_W-1:0]      cmt_idx;
    logic [DATA_WIDTH-1:0] cmt_data;
    logic                  cmt_err;

    axil_wr_collector #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_REG0    (RO_REG0)
    ) u_wr (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .AWADDR     (AWADDR),
        .AWVALID    (AWVALID),
        .AWREADY    (AWREADY),
        .WDATA      (WDATA),
        .WVALID     (WVALID),
        .WREADY     (WREADY),
        .BRESP      (BRESP),
        .BVALID     (BVALID),
        .BREADY     (BREADY),
        .cmt_o      (cmt),
        .cmt_idx_o  (cmt_idx),
        .cmt_data_o (cmt_data),
        .cmt_err_o  (cmt_err)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)              regs_q          <= '0;
        else if (cmt && !cmt_err)  regs_q[cmt_idx] <= cmt_data;
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = (RO_REG0 && i == 0) ? ID_WORD : regs_q[i];
    end

    rd_state_e             rstate_q;
    logic                  arready_q, rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    axi_resp_e             rresp_q;
    logic [IDX_W-1:0]      ar_idx;
    logic                  ar_err;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_idx  = ARADDR[ADDR_LSB +: IDX_W];
    assign ar_err  = (ARADDR >> (ADDR_LSB + IDX_W)) != '0;
    // Sampled before any same-edge write lands, so a colliding read sees the old value.
    assign rd_word = (RO_REG0 && ar_idx == '0) ? ID_WORD : regs_q[ar_idx];

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ARVALID && arready_q) begin
                        rstate_q  <= R_RESP;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= ar_err ? SLVERR : OKAY;
                        rdata_q   <= ar_err ? '0 : rd_word;
                    end
                end
                R_RESP: if (RREADY) begin
                    rstate_q  <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed bench for axil_regfile_slave with a transaction-level reference model
// compared against every output on each falling clock edge.
module tb_axil_regfile_slave;

`ifdef AXIL_REGFILE_ID_REG_EN
    localparam bit ID_EN = 1'b1;
`else
    localparam bit ID_EN = 1'b0;
`endif
    localparam int NREG = 8;
    localparam logic [31:0] ID_VAL = 32'hA11C_0001;

    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [31:0]  AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic         AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic         AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]   BRESP, RRESP;
    logic [31:0]  RDATA;
    logic [NREG*32-1:0] reg_out;

    int n_chk = 0;
    int n_fail = 0;

    always #5 ACLK = ~ACLK;

    axil_regfile_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NREG), .ID_VALUE(ID_VAL)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out)
    );

    // Reference model state
    logic [31:0] mem [NREG];
    logic        aw_held, w_held;
    logic [31:0] aw_a, w_d;
    logic        e_awready, e_wready, e_arready, e_bvalid, e_rvalid;
    logic [1:0]  e_bresp, e_rresp;
    logic [31:0] e_rdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
        return (a / 4) >= NREG;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % NREG);
    endfunction

    function automatic logic [31:0] reg_val(input int i);
        return (ID_EN && i == 0) ? ID_VAL : mem[i];
    endfunction

    function automatic logic [1:0] wr_resp(input logic [31:0] a);
        return (out_of_range(a) || (ID_EN && idx_of(a) == 0)) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        aw_held = 0; w_held = 0; aw_a = '0; w_d = '0;
        e_awready = 0; e_wready = 0; e_arready = 0; e_bvalid = 0; e_rvalid = 0;
        e_bresp = 2'b00; e_rresp = 2'b00; e_rdata = '0;
    endtask

    // One clock: handshakes decided from inputs and predicted readys before the edge.
    task automatic cycle();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        aw_hs = AWVALID && e_awready;
        w_hs  = WVALID && e_wready;
        b_hs  = e_bvalid && BREADY;
        ar_hs = ARVALID && e_arready;
        r_hs  = e_rvalid && RREADY;
        @(posedge ACLK);
        if (!ARESETn) begin
            model_reset();
        end else begin
            if (ar_hs) begin
                e_rvalid = 1;
                e_rresp  = out_of_range(ARADDR) ? 2'b10 : 2'b00;
                e_rdata  = out_of_range(ARADDR) ? 32'h0 : reg_val(idx_of(ARADDR));
            end else if (r_hs) e_rvalid = 0;
            if (aw_hs) begin aw_held = 1; aw_a = AWADDR; end
            if (w_hs)  begin w_held = 1;  w_d = WDATA; end
            if (aw_held && w_held) begin
                e_bresp = wr_resp(aw_a);
                if (e_bresp == 2'b00) mem[idx_of(aw_a)] = w_d;
                e_bvalid = 1; aw_held = 0; w_held = 0;
            end else if (b_hs) e_bvalid = 0;
            e_awready = !aw_held && !e_bvalid;
            e_wready  = !w_held && !e_bvalid;
            e_arready = !e_rvalid;
        end
        @(negedge ACLK);
    endtask

    always @(negedge ACLK) begin
        chk("awready", AWREADY, e_awready);
        chk("wready", WREADY, e_wready);
        chk("arready", ARREADY, e_arready);
        chk("bvalid", BVALID, e_bvalid);
        chk("rvalid", RVALID, e_rvalid);
        if (e_bvalid) chk("bresp", BRESP, e_bresp);
        if (e_rvalid) begin
            chk("rdata", RDATA, e_rdata);
            chk("rresp", RRESP, e_rresp);
        end
        for (int i = 0; i < NREG; i++) chk("reg_out", reg_out[i*32 +: 32], reg_val(i));
    end

    task automatic wr_issue(input logic [31:0] a, input logic [31:0] d);
        AWADDR = a; WDATA = d; AWVALID = 1; WVALID = 1;
        for (int i = 0; i < 8 && (AWVALID || WVALID); i++) begin
            bit acc_aw, acc_w;
            acc_aw = AWVALID && e_awready;
            acc_w  = WVALID && e_wready;
            cycle();
            if (acc_aw) AWVALID = 0;
            if (acc_w)  WVALID = 0;
        end
        if (AWVALID || WVALID) begin
            chk("wr_issue_timeout", 1, 0);
            AWVALID = 0; WVALID = 0;
        end
    endtask

    task automatic b_accept();
        BREADY = 1;
        for (int i = 0; i < 8 && e_bvalid; i++) cycle();
        if (e_bvalid) chk("b_accept_timeout", 1, 0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        wr_issue(a, d);
        chk("wr_bvalid", BVALID, 1);
        chk("wr_bresp", BRESP, resp);
        b_accept();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
        ARADDR = a; ARVALID = 1; RREADY = 0;
        for (int i = 0; i < 8 && ARVALID; i++) begin
            bit acc;
            acc = e_arready;
            cycle();
            if (acc) ARVALID = 0;
        end
        if (ARVALID) begin chk("rd_timeout", 1, 0); ARVALID = 0; end
        chk("rd_rvalid", RVALID, 1);
        chk("rd_data", RDATA, d);
        chk("rd_resp", RRESP, resp);
        RREADY = 1;
        cycle();
        RREADY = 0;
    endtask

    task automatic pulse_reset();
        #2 ARESETn = 0;
        #1;
        chk("rst_async_outs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP}, 0);
        chk("rst_async_rdata", RDATA, 0);
        chk("rst_async_regs", (reg_out == {(NREG*32){ID_EN ? 1'b0 : 1'b0}}) ||
                              (ID_EN && reg_out[NREG*32-1:32] == '0), 1);
        model_reset();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        @(negedge ACLK);
        ARESETn = 1;
    endtask

    initial begin
        logic [NREG*32-1:0] saved;
        model_reset();
        repeat (2) @(negedge ACLK);
        chk("reset_outs", {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
        chk("reset_regs", reg_out[NREG*32-1:32], 0);
        ARESETn = 1;
        cycle();
        chk("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

        // AW and W together
        BREADY = 1;
        wr_issue(32'h04, 32'hDEAD_BEEF);
        chk("t1_bvalid", BVALID, 1);
        chk("t1_bresp", BRESP, 2'b00);
        chk("t1_reg1", reg_out[63:32], 32'hDEAD_BEEF);
        b_accept();
        rd(32'h04, 32'hDEAD_BEEF, 2'b00);

        // W three cycles ahead of AW, B held off for 5 cycles
        BREADY = 0;
        WDATA = 32'h1234; WVALID = 1;
        cycle(); WVALID = 0;
        cycle(); cycle();
        chk("t2_have_w_awready", AWREADY, 1);
        AWADDR = 32'h08; AWVALID = 1;
        cycle(); AWVALID = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_bvalid_hold", BVALID, 1);
            chk("t2_bresp_hold", BRESP, 2'b00);
            chk("t2_readys_low", {AWREADY, WREADY}, 2'b00);
            cycle();
        end
        chk("t2_reg2", reg_out[95:64], 32'h1234);
        b_accept();

        // Out-of-range write and read
        saved = reg_out;
        wr(32'h20, 32'hFFFF_FFFF, 2'b10);
        chk("t3_no_change", reg_out == saved, 1);
        rd(32'h100, 32'h0, 2'b10);

        // Read colliding with a write commit to the same register
        wr(32'h0C, 32'h5, 2'b00);
        BREADY = 0; RREADY = 0;
        AWADDR = 32'h0C; WDATA = 32'hA; AWVALID = 1; WVALID = 1;
        ARADDR = 32'h0C; ARVALID = 1;
        cycle();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        chk("t4_old_value", RDATA, 32'h5);
        chk("t4_rvalid", RVALID, 1);
        chk("t4_reg3_new", reg_out[127:96], 32'hA);
        RREADY = 1; BREADY = 1;
        cycle();
        RREADY = 0;
        rd(32'h0C, 32'hA, 2'b00);

        // Reset with BVALID up, then with only AW captured
        BREADY = 0;
        wr_issue(32'h10, 32'h99);
        chk("t5_bvalid_before", BVALID, 1);
        pulse_reset();
        cycle();
        AWADDR = 32'h14; AWVALID = 1;
        cycle(); AWVALID = 0;
        cycle();
        chk("t5_aw_only", {AWREADY, WREADY}, 2'b01);
        pulse_reset();
        cycle();
        WDATA = 32'h77; WVALID = 1;
        cycle(); WVALID = 0;
        cycle(); cycle();
        chk("t5_w_alone_no_b", BVALID, 0);
        chk("t5_w_alone_reg5", reg_out[191:160], 0);
        BREADY = 1;
        pulse_reset();
        cycle();

        // Register 0
        if (ID_EN) begin
            rd(32'h00, ID_VAL, 2'b00);
            wr(32'h00, 32'h55, 2'b10);
            rd(32'h00, ID_VAL, 2'b00);
            chk("t6_reg0_id", reg_out[31:0], ID_VAL);
        end else begin
            wr(32'h00, 32'h55, 2'b00);
            rd(32'h00, 32'h55, 2'b00);
            chk("t6_reg0_rw", reg_out[31:0], 32'h55);
        end

        cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
